// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - pipeline controller signal bundle (predictor, decode, execute, memory, controls)
interface pipe_ctrl_if;
    logic        jump_taken_predict;
    logic [29:0] jump_target_predict;
    logic        imem_ready;
    logic        dmem_ready;
    logic        id_valid;
    logic        id_uncond_jump;
    logic [31:0] uncond_jump_addr_id;
    logic [31:0] cond_jump_addr_id;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        id_md_start;
    logic        ex_valid;
    logic        ex_cond_branch;
    logic        ex_branch_taken;
    logic        ex_load;
    logic        ex_mem_op;
    logic [4:0]  ex_rd;
    logic        stall_pc;
    logic        stall_if_id;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        uncond_jump_predict_fail_id;
    logic        cond_jump_predict_fail_ex;
    logic        cond_jump_taken_ex;
    logic        md_busy;
    logic        bp_update_valid;
    logic        bp_update_taken;

    modport master (
        output jump_taken_predict, jump_target_predict, imem_ready, dmem_ready,
               id_valid, id_uncond_jump, uncond_jump_addr_id, cond_jump_addr_id,
               id_rs, id_rt, id_uses_rt, id_md_start, ex_valid, ex_cond_branch,
               ex_branch_taken, ex_load, ex_mem_op, ex_rd,
        input  stall_pc, stall_if_id, flush_if_id, flush_id_ex,
               uncond_jump_predict_fail_id, cond_jump_predict_fail_ex,
               cond_jump_taken_ex, md_busy, bp_update_valid, bp_update_taken
    );

    modport slave (
        input  jump_taken_predict, jump_target_predict, imem_ready, dmem_ready,
               id_valid, id_uncond_jump, uncond_jump_addr_id, cond_jump_addr_id,
               id_rs, id_rt, id_uses_rt, id_md_start, ex_valid, ex_cond_branch,
               ex_branch_taken, ex_load, ex_mem_op, ex_rd,
        output stall_pc, stall_if_id, flush_if_id, flush_id_ex,
               uncond_jump_predict_fail_id, cond_jump_predict_fail_ex,
               cond_jump_taken_ex, md_busy, bp_update_valid, bp_update_taken
    );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall/flush/redirect controller with mul/div FSM; optional PIPE_CTRL_PERF_EN counters
module pipe_ctrl #(
    parameter int MD_LAT = 32
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_mispredict,
    output logic [31:0] perf_stall
`endif
);
    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

    localparam logic [7:0] MD_LOAD = 8'(MD_LAT - 1);

    md_state_t   md_state, md_next;
    logic [7:0]  md_cnt, md_cnt_next;

    logic        pred_taken_id, pred_taken_ex;
    logic [29:0] pred_target_id, pred_target_ex;
    logic [31:0] cond_addr_ex;

    logic md_busy_c, freeze, ex_fail, id_fail_raw, id_fail, load_use, id_ex_adv;
    logic ex_cti, id_cti_upd;
    logic stall_pc_c, stall_if_id_c, flush_if_id_c, flush_id_ex_c;
    logic bp_valid_c, bp_taken_c;

    assign md_busy_c = (md_state == MD_BUSY) & ~rst;
    assign freeze    = ~bus.imem_ready | (bus.ex_mem_op & ~bus.dmem_ready)
                     | (md_busy_c & bus.id_md_start);

    // A non-branch in EX that was predicted taken is a false BTB hit and must redirect too
    assign ex_fail = bus.ex_valid &
                     ((bus.ex_cond_branch &
                       ((bus.ex_branch_taken != pred_taken_ex) |
                        (bus.ex_branch_taken & (pred_target_ex != cond_addr_ex[31:2])))) |
                      (~bus.ex_cond_branch & pred_taken_ex));

    assign id_fail_raw = bus.id_valid & bus.id_uncond_jump &
                         (~pred_taken_id | (pred_target_id != bus.uncond_jump_addr_id[31:2]));
    assign id_fail     = id_fail_raw & ~ex_fail;

    assign load_use = bus.ex_valid & bus.ex_load & (bus.ex_rd != 5'd0) & bus.id_valid &
                      ((bus.ex_rd == bus.id_rs) | (bus.id_uses_rt & (bus.ex_rd == bus.id_rt))) &
                      ~(ex_fail | id_fail);

    // A stalled ID jump would otherwise train the predictor twice
    assign ex_cti     = bus.ex_valid & bus.ex_cond_branch;
    assign id_cti_upd = bus.id_valid & bus.id_uncond_jump & ~ex_fail & ~load_use;

    always_comb begin
        stall_pc_c    = 1'b0;
        stall_if_id_c = 1'b0;
        flush_if_id_c = 1'b0;
        flush_id_ex_c = 1'b0;
        bp_valid_c    = 1'b0;
        bp_taken_c    = 1'b0;
        if (rst) begin
            stall_pc_c    = 1'b1;
            stall_if_id_c = 1'b1;
            flush_if_id_c = 1'b1;
        end else if (freeze) begin
            stall_pc_c    = 1'b1;
            stall_if_id_c = 1'b1;
        end else begin
            stall_pc_c    = load_use;
            stall_if_id_c = load_use;
            flush_if_id_c = ex_fail | id_fail;
            flush_id_ex_c = ex_fail | load_use;
            bp_valid_c    = ex_cti | id_cti_upd;
            bp_taken_c    = ex_cti ? bus.ex_branch_taken : id_cti_upd;
        end
    end

    assign id_ex_adv = ~freeze & ~flush_id_ex_c;

    assign bus.stall_pc                    = stall_pc_c;
    assign bus.stall_if_id                 = stall_if_id_c;
    assign bus.flush_if_id                 = flush_if_id_c;
    assign bus.flush_id_ex                 = flush_id_ex_c;
    assign bus.uncond_jump_predict_fail_id = id_fail & ~rst;
    assign bus.cond_jump_predict_fail_ex   = ex_fail & ~rst;
    assign bus.cond_jump_taken_ex          = ex_cti & bus.ex_branch_taken & ~rst;
    assign bus.md_busy                     = md_busy_c;
    assign bus.bp_update_valid             = bp_valid_c;
    assign bus.bp_update_taken             = bp_taken_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_taken_id  <= 1'b0;
            pred_target_id <= '0;
        end else if (flush_if_id_c) begin
            pred_taken_id  <= 1'b0;
            pred_target_id <= '0;
        end else if (!stall_if_id_c) begin
            pred_taken_id  <= bus.jump_taken_predict;
            pred_target_id <= bus.jump_target_predict;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_id_ex_c) begin
            pred_taken_ex  <= 1'b0;
            pred_target_ex <= '0;
            cond_addr_ex   <= '0;
        end else if (!freeze) begin
            pred_taken_ex  <= pred_taken_id;
            pred_target_ex <= pred_target_id;
            cond_addr_ex   <= bus.cond_jump_addr_id;
        end
    end

    // The counter runs through freezes; only the issuing side is held
    always_ff @(posedge clk) begin
        if (rst) begin
            md_state <= MD_IDLE;
            md_cnt   <= '0;
        end else begin
            md_state <= md_next;
            md_cnt   <= md_cnt_next;
        end
    end

    always_comb begin
        md_next     = md_state;
        md_cnt_next = md_cnt;
        case (md_state)
            MD_IDLE: begin
                if (bus.id_md_start && id_ex_adv) begin
                    md_next     = MD_BUSY;
                    md_cnt_next = MD_LOAD;
                end
            end
            MD_BUSY: begin
                if (md_cnt == 8'd0) md_next = MD_DONE;
                else                md_cnt_next = md_cnt - 8'd1;
            end
            MD_DONE: md_next = MD_IDLE;
            default: md_next = MD_IDLE;
        endcase
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_mispredict <= '0;
            perf_stall      <= '0;
        end else begin
            if (!freeze && (ex_fail || id_fail)) perf_mispredict <= perf_mispredict + 32'd1;
            if (stall_pc_c)                      perf_stall      <= perf_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl (MD_LAT=4)
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    pipe_ctrl_if bus ();

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_mispredict, perf_stall;
`endif

    pipe_ctrl #(.MD_LAT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_mispredict (perf_mispredict),
        .perf_stall      (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.jump_taken_predict  = 1'b0;
        bus.jump_target_predict = '0;
        bus.imem_ready          = 1'b1;
        bus.dmem_ready          = 1'b1;
        bus.id_valid            = 1'b0;
        bus.id_uncond_jump      = 1'b0;
        bus.uncond_jump_addr_id = '0;
        bus.cond_jump_addr_id   = '0;
        bus.id_rs               = '0;
        bus.id_rt               = '0;
        bus.id_uses_rt          = 1'b0;
        bus.id_md_start         = 1'b0;
        bus.ex_valid            = 1'b0;
        bus.ex_cond_branch      = 1'b0;
        bus.ex_branch_taken     = 1'b0;
        bus.ex_load             = 1'b0;
        bus.ex_mem_op           = 1'b0;
        bus.ex_rd               = '0;
    endtask

    // Push a prediction through IF and ID so it sits in EX with the given branch target
    task automatic load_ex(input logic t, input logic [29:0] tgt, input logic [31:0] addr);
        idle_inputs();
        bus.jump_taken_predict  = t;
        bus.jump_target_predict = tgt;
        tick();
        bus.jump_taken_predict  = 1'b0;
        bus.jump_target_predict = '0;
        bus.cond_jump_addr_id   = addr;
        tick();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_stall_pc", bus.stall_pc, 1);
        chk("rst_stall_if_id", bus.stall_if_id, 1);
        chk("rst_flush_if_id", bus.flush_if_id, 1);
        chk("rst_flush_id_ex", bus.flush_id_ex, 0);
        chk("rst_md_busy", bus.md_busy, 0);
        chk("rst_bp_valid", bus.bp_update_valid, 0);
        rst = 1'b0;
        #1;
        chk("idle_stall_pc", bus.stall_pc, 0);
        chk("idle_flush_if_id", bus.flush_if_id, 0);

        // Jump predicted to 0x100, resolves to 0x104 in ID
        bus.jump_taken_predict  = 1'b1;
        bus.jump_target_predict = 30'h40;
        tick();
        idle_inputs();
        bus.id_valid            = 1'b1;
        bus.id_uncond_jump      = 1'b1;
        bus.uncond_jump_addr_id = 32'h104;
        #1;
        chk("jfail_id", bus.uncond_jump_predict_fail_id, 1);
        chk("jfail_flush_if_id", bus.flush_if_id, 1);
        chk("jfail_flush_id_ex", bus.flush_id_ex, 0);
        chk("jfail_bp_valid", bus.bp_update_valid, 1);
        chk("jfail_bp_taken", bus.bp_update_taken, 1);
        tick();
        idle_inputs();
        #1;
        chk("jfail_one_cycle", bus.flush_if_id, 0);
        tick();

        // Jump predicted correctly to 0x104
        bus.jump_taken_predict  = 1'b1;
        bus.jump_target_predict = 30'h41;
        tick();
        idle_inputs();
        bus.id_valid            = 1'b1;
        bus.id_uncond_jump      = 1'b1;
        bus.uncond_jump_addr_id = 32'h104;
        #1;
        chk("jok_fail", bus.uncond_jump_predict_fail_id, 0);
        chk("jok_flush", bus.flush_if_id, 0);
        chk("jok_bp_valid", bus.bp_update_valid, 1);
        tick();
        idle_inputs();
        tick();

        // beq predicted not-taken, actually taken
        load_ex(1'b0, 30'h0, 32'h200);
        bus.ex_valid        = 1'b1;
        bus.ex_cond_branch  = 1'b1;
        bus.ex_branch_taken = 1'b1;
        #1;
        chk("bfail_ex", bus.cond_jump_predict_fail_ex, 1);
        chk("bfail_taken", bus.cond_jump_taken_ex, 1);
        chk("bfail_flush_if_id", bus.flush_if_id, 1);
        chk("bfail_flush_id_ex", bus.flush_id_ex, 1);
        chk("bfail_bp_taken", bus.bp_update_taken, 1);
        tick();
        idle_inputs();
        #1;
        chk("bfail_after", bus.flush_id_ex, 0);

        // Taken with correct target: no redirect
        load_ex(1'b1, 30'h80, 32'h200);
        bus.ex_valid        = 1'b1;
        bus.ex_cond_branch  = 1'b1;
        bus.ex_branch_taken = 1'b1;
        #1;
        chk("bok_fail", bus.cond_jump_predict_fail_ex, 0);
        chk("bok_flush_id_ex", bus.flush_id_ex, 0);

        // Taken with wrong predicted target
        load_ex(1'b1, 30'h84, 32'h200);
        bus.ex_valid        = 1'b1;
        bus.ex_cond_branch  = 1'b1;
        bus.ex_branch_taken = 1'b1;
        #1;
        chk("btgt_fail", bus.cond_jump_predict_fail_ex, 1);

        // False BTB hit on a non-branch
        load_ex(1'b1, 30'h80, 32'h200);
        bus.ex_valid = 1'b1;
        #1;
        chk("fhit_fail", bus.cond_jump_predict_fail_ex, 1);
        chk("fhit_taken", bus.cond_jump_taken_ex, 0);
        chk("fhit_bp_valid", bus.bp_update_valid, 0);

        // EX fail and ID fail in the same cycle
        load_ex(1'b0, 30'h0, 32'h300);
        bus.ex_valid            = 1'b1;
        bus.ex_cond_branch      = 1'b1;
        bus.ex_branch_taken     = 1'b1;
        bus.id_valid            = 1'b1;
        bus.id_uncond_jump      = 1'b1;
        bus.uncond_jump_addr_id = 32'h400;
        #1;
        chk("both_id_masked", bus.uncond_jump_predict_fail_id, 0);
        chk("both_ex_fail", bus.cond_jump_predict_fail_ex, 1);
        chk("both_flush_id_ex", bus.flush_id_ex, 1);

        // Redirect held through an instruction-fetch freeze
        load_ex(1'b0, 30'h0, 32'h300);
        bus.ex_valid        = 1'b1;
        bus.ex_cond_branch  = 1'b1;
        bus.ex_branch_taken = 1'b1;
        bus.imem_ready      = 1'b0;
        #1;
        chk("frz_fail", bus.cond_jump_predict_fail_ex, 1);
        chk("frz_flush_if_id", bus.flush_if_id, 0);
        chk("frz_stall_pc", bus.stall_pc, 1);
        chk("frz_bp_valid", bus.bp_update_valid, 0);
        tick();
        chk("frz_hold_fail", bus.cond_jump_predict_fail_ex, 1);
        bus.imem_ready = 1'b1;
        #1;
        chk("frz_release_flush", bus.flush_id_ex, 1);
        tick();
        idle_inputs();
        tick();

        // Load-use hazards
        bus.ex_valid  = 1'b1;
        bus.ex_load   = 1'b1;
        bus.ex_mem_op = 1'b1;
        bus.ex_rd     = 5'd5;
        bus.id_valid  = 1'b1;
        bus.id_rs     = 5'd5;
        #1;
        chk("lu_stall_pc", bus.stall_pc, 1);
        chk("lu_stall_if_id", bus.stall_if_id, 1);
        chk("lu_flush_id_ex", bus.flush_id_ex, 1);
        chk("lu_flush_if_id", bus.flush_if_id, 0);
        bus.id_rs = 5'd3;
        bus.id_rt = 5'd5;
        #1;
        chk("lu_rt_unused", bus.stall_pc, 0);
        bus.id_uses_rt = 1'b1;
        #1;
        chk("lu_rt_used", bus.stall_pc, 1);
        bus.ex_rd = 5'd0;
        bus.id_rs = 5'd0;
        bus.id_rt = 5'd0;
        #1;
        chk("lu_r0", bus.stall_pc, 0);
        idle_inputs();
        tick();

        // div followed by div, MD_LAT=4
        bus.id_valid    = 1'b1;
        bus.id_md_start = 1'b1;
        #1;
        chk("md_start_busy", bus.md_busy, 0);
        chk("md_start_stall", bus.stall_pc, 0);
        tick();
        chk("md_c1_busy", bus.md_busy, 1);
        chk("md_c1_stall", bus.stall_pc, 1);
        chk("md_c1_flush", bus.flush_id_ex, 0);
        tick();
        bus.ex_mem_op  = 1'b1;
        bus.dmem_ready = 1'b0;
        #1;
        chk("md_c2_busy", bus.md_busy, 1);
        chk("md_c2_stall", bus.stall_if_id, 1);
        tick();
        bus.dmem_ready = 1'b1;
        #1;
        chk("md_c3_busy", bus.md_busy, 1);
        tick();
        chk("md_c4_busy", bus.md_busy, 1);
        bus.ex_mem_op = 1'b0;
        tick();
        chk("md_done_busy", bus.md_busy, 0);
        chk("md_done_release", bus.stall_pc, 0);
        idle_inputs();
        tick();
        tick();

        // Flush on the start cycle cancels the start
        bus.id_valid    = 1'b1;
        bus.id_md_start = 1'b1;
        bus.id_rs       = 5'd5;
        bus.ex_valid    = 1'b1;
        bus.ex_load     = 1'b1;
        bus.ex_mem_op   = 1'b1;
        bus.ex_rd       = 5'd5;
        #1;
        chk("mdf_flush", bus.flush_id_ex, 1);
        tick();
        idle_inputs();
        #1;
        chk("mdf_no_start", bus.md_busy, 0);

        // Reset while busy
        bus.id_valid    = 1'b1;
        bus.id_md_start = 1'b1;
        tick();
        idle_inputs();
        #1;
        chk("mdr_busy", bus.md_busy, 1);
        rst = 1'b1;
        #1;
        chk("mdr_rst_out", bus.md_busy, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("mdr_idle", bus.md_busy, 0);

`ifdef PIPE_CTRL_PERF_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("perf_rst_mis", perf_mispredict, 0);
        chk("perf_rst_stall", perf_stall, 0);
        bus.id_valid            = 1'b1;
        bus.id_uncond_jump      = 1'b1;
        bus.uncond_jump_addr_id = 32'h500;
        tick();
        tick();
        tick();
        idle_inputs();
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        idle_inputs();
        #1;
        chk("perf_mis", perf_mispredict, 3);
        chk("perf_stall", perf_stall, 5);
        rst = 1'b1;
        tick();
        chk("perf_clr_mis", perf_mispredict, 0);
        chk("perf_clr_stall", perf_stall, 0);
        rst = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline controller that drives the PC generator and the IF/ID and ID/EX pipeline registers. It carries each fetched instruction's branch prediction down to ID and EX, and it detects unconditional-jump mispredictions in ID and conditional-branch mispredictions in EX. It also produces stall and flush controls for load-use hazards, memory wait states and the multi-cycle mul/div unit. It sits beside the PC generator and consumes signals from the branch predictor, decode, execute and memory ports.

## Interface
Parameters:
- MD_LAT, 32: mul/div busy cycles after start (2..255).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- jump_taken_predict  in  1  BTB hit/taken for the instruction fetched this cycle.
- jump_target_predict  in  30  predicted target [31:2].
- imem_ready  in  1  instruction fetch completed this cycle.
- dmem_ready  in  1  data access complete (only meaningful when ex_mem_op).
- id_valid  in  1  ID holds a real instruction.
- id_uncond_jump  in  1  ID instruction is j/jal/jr.
- uncond_jump_addr_id  in  32  resolved unconditional target.
- cond_jump_addr_id  in  32  conditional target computed in ID.
- id_rs, id_rt  in  5 each  ID source registers.
- id_uses_rt  in  1  rt is a source.
- id_md_start  in  1  ID instruction is mul/div.
- ex_valid  in  1  EX holds a real instruction.
- ex_cond_branch  in  1  EX instruction is beq/bne.
- ex_branch_taken  in  1  EX compare result.
- ex_load  in  1  EX instruction is a load.
- ex_mem_op  in  1  EX instruction is a load or store.
- ex_rd  in  5  EX destination register.
- stall_pc  out  1  hold PC.
- stall_if_id  out  1  hold IF/ID register.
- flush_if_id  out  1  bubble IF/ID on next edge.
- flush_id_ex  out  1  bubble ID/EX on next edge.
- uncond_jump_predict_fail_id  out  1  ID redirect.
- cond_jump_predict_fail_ex  out  1  EX redirect.
- cond_jump_taken_ex  out  1  actual EX branch direction.
- md_busy  out  1  mul/div in progress.
- bp_update_valid, bp_update_taken  out  1 each  predictor training strobe and direction.

## Operation
- Prediction pipeline:
  - {pred_taken, pred_target} registered IF->ID when IF/ID advances; zeroed when IF/ID is flushed.
  - Copied ID->EX when ID/EX advances, together with cond_jump_addr_id. Copied as zero when ID/EX is flushed.
- Unconditional fail: id_valid & id_uncond_jump & (~pred_taken_id | pred_target_id != uncond_jump_addr_id[31:2]).
- Conditional fail:
  - ex_valid & ex_cond_branch & (ex_branch_taken != pred_taken_ex | (ex_branch_taken & pred_target_ex != cond_addr_ex[31:2])).
  - ex_valid & ~ex_cond_branch & pred_taken_ex (a false BTB hit) is also a conditional fail, with cond_jump_taken_ex=0.
- cond_jump_taken_ex = ex_valid & ex_cond_branch & ex_branch_taken.
- Redirect priority:
  - An EX fail masks the ID fail; uncond_jump_predict_fail_id is forced 0 while cond_jump_predict_fail_ex=1.
  - EX fail: flush_if_id=1, flush_id_ex=1.
  - ID fail: flush_if_id=1.
- Load-use hazard: ex_valid & ex_load & ex_rd!=0 & id_valid & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
  - Result: stall_pc=1, stall_if_id=1, flush_id_ex=1.
  - Suppressed while any redirect is active.
- Mem/md freeze:
  - Freeze condition: ~imem_ready | (ex_mem_op & ~dmem_ready) | (md_busy & id_md_start).
  - During a freeze, every stall output is 1 and every flush output is 0, so the whole pipeline holds.
  - Redirect outputs stay asserted and stable during a freeze and take effect on the first unfrozen edge.
- Mul/div FSM, states IDLE/BUSY/DONE:
  - IDLE -> BUSY when id_md_start & ID/EX advances; counter loads MD_LAT-1.
  - BUSY decrements each cycle. At counter 0 -> DONE.
  - DONE -> IDLE after one cycle.
  - md_busy=1 in BUSY only.
  - A flush_id_ex on the start cycle prevents the start.
- Predictor training: bp_update_valid=1 for one cycle per resolved CTI, in ID for unconditional and EX for conditional. It is gated by no freeze, and an ID update is gated by no EX fail. bp_update_taken=1 for jumps and equals ex_branch_taken for conditional branches.

## Timing
- Reset:
  - All outputs are 0 except stall_pc, stall_if_id and flush_if_id, which are 1 during reset.
  - Prediction registers, cond_addr_ex and the counter are 0; FSM is IDLE.
- All outputs are combinational from the current inputs plus registered state, so the PC updates on the same edge as a redirect.
- Redirect penalty: 1 bubble for an ID fail, 2 bubbles for an EX fail.
- Load-use costs exactly 1 bubble.
- A mul/div followed by a second mul/div stalls MD_LAT cycles minus the elapsed gap.
- rst during BUSY returns to IDLE on the next edge.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - Adds outputs perf_mispredict[31:0] (incremented on each effective redirect edge) and perf_stall[31:0] (incremented on each cycle with stall_pc=1 and rst=0).
  - Both counters wrap at 2^32 and are reset to 0.
- PIPE_CTRL_PERF_EN undefined: these ports and counters are absent.

## Test plan
- Predicted taken to 0x100, ID jump target 0x104 -> uncond_jump_predict_fail_id=1, flush_if_id=1 for exactly 1 cycle; PC next = 0x104.
- beq predicted not-taken, actually taken -> cond_jump_predict_fail_ex=1, cond_jump_taken_ex=1, both flushes=1; 2 bubbles.
- Same cycle: EX fail plus ID uncond fail -> only the EX fail asserts; the ID instruction is flushed.
- lw r5 in EX, add reading r5 in ID -> 1-cycle stall_pc/stall_if_id with flush_id_ex; no stall when ex_rd=0.
- MD_LAT=4: div, then div next cycle -> md_busy for 4 cycles, second div held until DONE; with dmem_ready=0 mid-sequence, the FSM keeps counting and the pipeline freezes.
- PIPE_CTRL_PERF_EN: 3 mispredicts plus 5 stall cycles -> perf_mispredict=3, perf_stall=5; rst clears both.
